logicnet_lut_layer_pipe: RTL and testbench

// - Parametrised, pipelined layer of NEURONS truth-table neurons.
// - Each neuron maps its own ADDR_W-bit input slice to OUT_W bits through a table held in distributed RAM.
// - Tables are runtime-loadable through a config port and cleared by hardware after reset.
// - valid/ready stream in, valid/ready stream out; sits between fan-in wiring and the next layer.

---
 rtl/logicnet_pkg.sv | 17 +
 rtl/logicnet_lut_ram.sv | 27 ++
 rtl/logicnet_lut_layer_pipe.sv | 112 +++++++++++
 tb/tb_logicnet_lut_layer_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logicnet_pkg.sv
// rtl/logicnet_pkg.sv - shared types and constants for the LUT neuron layer
package logicnet_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  // Index width for a neuron count; a single neuron still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/logicnet_lut_ram.sv
// rtl/logicnet_lut_ram.sv - one neuron truth table, sync write / async read
module logicnet_lut_ram #(
  parameter int ADDR_W = 8,
  parameter int OUT_W  = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [OUT_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [OUT_W-1:0]  rdata
);

  localparam int TAB_DEPTH = 2 ** ADDR_W;

  (* ram_style = "distributed", rom_style = "distributed" *)
  logic [OUT_W-1:0] mem [TAB_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/logicnet_lut_layer_pipe.sv
// rtl/logicnet_lut_layer_pipe.sv - pipelined layer of runtime-loadable LUT neurons
module logicnet_lut_layer_pipe
  import logicnet_pkg::*;
#(
  parameter int NEURONS = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int OUT_W   = 1,
  parameter int CNT_W   = cnt_width(NEURONS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [CNT_W-1:0]          cfg_neuron,
  input  logic [ADDR_W-1:0]         cfg_addr,
  input  logic [OUT_W-1:0]          cfg_data,
  output logic                      cfg_ready,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NEURONS*ADDR_W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NEURONS*OUT_W-1:0]  out_data
);

  state_t                     state;
  state_t                     state_next;
  logic [ADDR_W-1:0]          clr_addr;
  logic                       clearing;
  logic                       cfg_hit;
  logic                       push;
  logic                       pop;
  logic [NEURONS*OUT_W-1:0]   lookup;
  logic [NEURONS*OUT_W-1:0]   fifo_mem [2];
  logic                       wr_ptr;
  logic                       rd_ptr;
  logic [1:0]                 occ;

  assign clearing = (state == CLEAR);

  always_comb begin
    state_next = state;
    if (state == CLEAR && clr_addr == {ADDR_W{1'b1}}) begin
      state_next = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_next;
      if (clearing) begin
        clr_addr <= clr_addr + ADDR_W'(1);
      end
    end
  end

  assign cfg_ready = (state == RUN);
  assign cfg_hit   = cfg_we & cfg_ready &
                     ({1'b0, cfg_neuron} < (CNT_W+1)'(NEURONS));

  // Any cfg_we stalls input, so a table is never read and written in one cycle.
  assign in_ready  = (state == RUN) & ~cfg_we & (occ != 2'd2);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
    logic we_n;

    assign we_n = clearing | (cfg_hit & (cfg_neuron == CNT_W'(n)));

    logicnet_lut_ram #(
      .ADDR_W (ADDR_W),
      .OUT_W  (OUT_W)
    ) u_ram (
      .clk   (clk),
      .we    (we_n),
      .waddr (clearing ? clr_addr : cfg_addr),
      .wdata (clearing ? {OUT_W{1'b0}} : cfg_data),
      .raddr (in_data[n*ADDR_W +: ADDR_W]),
      .rdata (lookup[n*OUT_W +: OUT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= lookup;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign out_valid = (occ != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_logicnet_lut_layer_pipe.sv
// tb/tb_logicnet_lut_layer_pipe.sv - scoreboard bench for the LUT neuron layer
module tb_logicnet_lut_layer_pipe;

  localparam int NEURONS = 4;
  localparam int ADDR_W  = 8;
  localparam int OUT_W   = 1;
  localparam int CNT_W   = 2;
  localparam int DEPTH   = 256;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      cfg_we;
  logic [CNT_W-1:0]          cfg_neuron;
  logic [ADDR_W-1:0]         cfg_addr;
  logic [OUT_W-1:0]          cfg_data;
  logic                      cfg_ready;
  logic                      in_valid;
  logic                      in_ready;
  logic [NEURONS*ADDR_W-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [NEURONS*OUT_W-1:0]  out_data;

  logicnet_lut_layer_pipe #(
    .NEURONS (NEURONS),
    .ADDR_W  (ADDR_W),
    .OUT_W   (OUT_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_neuron (cfg_neuron),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  int asserts  = 0;
  int failures = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

  logic [OUT_W-1:0]         model_tab [NEURONS][DEPTH];
  logic [NEURONS*OUT_W-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NEURONS*OUT_W-1:0] expect_of(input logic [NEURONS*ADDR_W-1:0] v);
    logic [NEURONS*OUT_W-1:0] r;
    for (int n = 0; n < NEURONS; n++) begin
      r[n*OUT_W +: OUT_W] = model_tab[n][v[n*ADDR_W +: ADDR_W]];
    end
    return r;
  endfunction

  function automatic void model_clear();
    for (int n = 0; n < NEURONS; n++)
      for (int a = 0; a < DEPTH; a++)
        model_tab[n][a] = '0;
  endfunction

  // Bias addresses towards a few hot entries so random writes get read back.
  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] a;
    case ($urandom_range(3))
      0:       a = 8'h00;
      1:       a = 8'hFF;
      2:       a = 8'($urandom_range(7));
      default: a = 8'($urandom);
    endcase
    return a;
  endfunction

  function automatic logic [NEURONS*ADDR_W-1:0] rand_vec();
    logic [NEURONS*ADDR_W-1:0] v;
    for (int n = 0; n < NEURONS; n++) v[n*ADDR_W +: ADDR_W] = rand_addr();
    return v;
  endfunction

  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(1));
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(out_valid), 64'(0));
      end else begin
        check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [NEURONS*ADDR_W-1:0] v, input bit chk_lat);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(expect_of(v));
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 64'(ok), 64'(1));
    if (chk_lat) check("latency_out_valid", 64'(out_valid), 64'(1));
  endtask

  task automatic cfg_write(input int n, input logic [ADDR_W-1:0] a, input logic [OUT_W-1:0] d);
    cfg_we     = 1'b1;
    cfg_neuron = CNT_W'(n);
    cfg_addr   = a;
    cfg_data   = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (n < NEURONS) model_tab[n][a] = d;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_left", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  // Counts cycles with cfg_ready low; optionally pokes a write mid-clear that must be ignored.
  task automatic wait_clear(input bit inject);
    int cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cfg_ready) break;
      check("in_ready_in_clear", 64'(in_ready), 64'(0));
      cnt++;
      if (inject && cnt == 100) begin
        cfg_we     = 1'b1;
        cfg_neuron = 2'd0;
        cfg_addr   = 8'h10;
        cfg_data   = 1'b1;
      end else begin
        cfg_we = 1'b0;
      end
    end
    cfg_we = 1'b0;
    check("clear_cycles", 64'(cnt), 64'(DEPTH));
    check("in_ready_after_clear", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NEURONS*ADDR_W-1:0] v;
    logic [NEURONS*OUT_W-1:0]  head;
    rst        = 1'b1;
    cfg_we     = 1'b0;
    cfg_neuron = '0;
    cfg_addr   = '0;
    cfg_data   = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_cfg_ready", 64'(cfg_ready), 64'(0));
    rst = 1'b0;
    wait_clear(1'b1);

    // Freshly cleared tables, including the entry poked during clear.
    send({8'h00, 8'hFF, 8'h5A, 8'h10}, 1'b0);
    for (int i = 0; i < 4; i++) send(rand_vec(), 1'b0);

    cfg_write(2, 8'h5A, 1'b1);
    send({8'h00, 8'h5A, 8'h00, 8'h00}, 1'b1);
    wait_drain();

    // Backpressure: two vectors fill the buffer, the third must stall.
    rdy_mode = 2;
    @(posedge clk); #1;
    send({8'h00, 8'h5A, 8'h00, 8'h00}, 1'b0);
    send({8'h00, 8'h00, 8'h00, 8'h00}, 1'b0);
    head     = exp_q[0];
    in_valid = 1'b1;
    in_data  = {8'h00, 8'h5A, 8'h5A, 8'h5A};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_out_data_hold", 64'(out_data), 64'(head));
    end
    rdy_mode = 0;
    send({8'h00, 8'h5A, 8'h5A, 8'h5A}, 1'b0);
    wait_drain();

    // Config write collides with a pending input vector.
    in_valid   = 1'b1;
    in_data    = {8'h00, 8'h00, 8'h33, 8'h00};
    cfg_we     = 1'b1;
    cfg_neuron = 2'd1;
    cfg_addr   = 8'h33;
    cfg_data   = 1'b1;
    @(negedge clk);
    check("cfg_stall_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model_tab[1][8'h33] = 1'b1;
    send({8'h00, 8'h00, 8'h33, 8'h00}, 1'b0);
    wait_drain();

    cfg_write(3, 8'hFF, 1'b1);
    cfg_write(3, 8'h00, 1'b1);
    send({8'hFF, 8'h00, 8'h00, 8'h00}, 1'b0);
    send({8'h00, 8'hFF, 8'hFF, 8'hFF}, 1'b0);
    send({8'h7F, 8'h00, 8'h00, 8'h00}, 1'b0);

    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0)
        cfg_write($urandom_range(NEURONS-1), rand_addr(), 1'($urandom_range(1)));
      else
        send(rand_vec(), 1'b0);
    end
    rdy_mode = 0;
    wait_drain();

    // Reset with a full buffer and a config write in flight.
    rdy_mode = 2;
    @(posedge clk); #1;
    send({8'h00, 8'h5A, 8'h33, 8'hFF}, 1'b0);
    send({8'hFF, 8'h00, 8'h00, 8'h00}, 1'b0);
    cfg_we     = 1'b1;
    cfg_neuron = 2'd0;
    cfg_addr   = 8'h77;
    cfg_data   = 1'b1;
    rst        = 1'b1;
    @(posedge clk); #1;
    rst    = 1'b0;
    cfg_we = 1'b0;
    check("rstmid_out_valid", 64'(out_valid), 64'(0));
    check("rstmid_cfg_ready", 64'(cfg_ready), 64'(0));
    exp_q.delete();
    model_clear();
    rdy_mode = 1;
    wait_clear(1'b0);
    for (int a = 0; a < DEPTH; a++) begin
      v = {8'(a), 8'(a), 8'(a), 8'(a)};
      send(v, 1'b0);
    end
    rdy_mode = 0;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
